// File: rtl/rf_writeback_scheduler.sv
// In-order writeback queue that drains up to two results per cycle onto the register file write ports.
// Optional busy_mask output is built when WB_BUSY_MASK_EN is defined.
module rf_writeback_scheduler #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enq0_valid,
    input  logic [ADDR_W-1:0]        enq0_addr,
    input  logic [DATA_W-1:0]        enq0_data,
    input  logic                     enq1_valid,
    input  logic [ADDR_W-1:0]        enq1_addr,
    input  logic [DATA_W-1:0]        enq1_data,
    output logic                     enq_ready,
    input  logic                     stall_wb,
    output logic                     wr0_enable,
    output logic [ADDR_W-1:0]        wr0_address,
    output logic [DATA_W-1:0]        wr0_data,
    output logic                     wr1_enable,
    output logic [ADDR_W-1:0]        wr1_address,
    output logic [DATA_W-1:0]        wr1_data,
`ifdef WB_BUSY_MASK_EN
    output logic [2**ADDR_W-1:0]     busy_mask,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_en0;
    logic              w_en1;
    logic [1:0]        w_enq_n;
    logic [1:0]        w_pop;
    logic [PW-1:0]     w_slot1;
    logic [PW-1:0]     w_h1;
    logic              w_same;

    assign count     = r_count;
    assign enq_ready = (CW'(DEPTH) - r_count) >= CW'(2);
    // R0 results are dropped here so they never occupy a slot
    assign w_en0     = enq_ready & enq0_valid & (enq0_addr != '0);
    assign w_en1     = enq_ready & enq1_valid & (enq1_addr != '0);
    assign w_enq_n   = {1'b0, w_en0} + {1'b0, w_en1};
    assign w_pop     = stall_wb ? 2'd0 :
                       (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
    assign w_slot1   = r_tail + PW'(w_en0);
    assign w_h1      = r_head + PW'(1);
    assign w_same    = r_addr[r_head] == r_addr[w_h1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            wr0_enable  <= 1'b0;
            wr0_address <= '0;
            wr0_data    <= '0;
            wr1_enable  <= 1'b0;
            wr1_address <= '0;
            wr1_data    <= '0;
        end else begin
            if (w_en0) begin
                r_addr[r_tail] <= enq0_addr;
                r_data[r_tail] <= enq0_data;
            end
            if (w_en1) begin
                r_addr[w_slot1] <= enq1_addr;
                r_data[w_slot1] <= enq1_data;
            end
            r_tail     <= r_tail + PW'(w_enq_n);
            r_head     <= r_head + PW'(w_pop);
            r_count    <= r_count + CW'(w_enq_n) - CW'(w_pop);
            wr0_enable <= 1'b0;
            wr1_enable <= 1'b0;
            if (w_pop == 2'd1) begin
                wr0_enable  <= 1'b1;
                wr0_address <= r_addr[r_head];
                wr0_data    <= r_data[r_head];
            end else if (w_pop == 2'd2) begin
                // Same-register pair: only the younger value reaches the file
                wr0_enable  <= !w_same;
                wr0_address <= r_addr[r_head];
                wr0_data    <= r_data[r_head];
                wr1_enable  <= 1'b1;
                wr1_address <= r_addr[w_h1];
                wr1_data    <= r_data[w_h1];
            end
        end
    end

`ifdef WB_BUSY_MASK_EN
    logic [2**ADDR_W-1:0] r_busy;
    logic [2**ADDR_W-1:0] w_busy_n;
    logic [PW-1:0]        w_head_n;
    logic [CW-1:0]        w_count_n;
    logic [PW-1:0]        w_off;
    logic [ADDR_W-1:0]    w_qa;

    assign w_head_n  = r_head + PW'(w_pop);
    assign w_count_n = r_count + CW'(w_enq_n) - CW'(w_pop);
    assign busy_mask = r_busy;

    // Mask reflects the queue and write ports as they will be after this edge
    always_comb begin
        w_busy_n = '0;
        w_off    = '0;
        w_qa     = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_off = PW'(j) - w_head_n;
            if (w_en0 && PW'(j) == r_tail)
                w_qa = enq0_addr;
            else if (w_en1 && PW'(j) == w_slot1)
                w_qa = enq1_addr;
            else
                w_qa = r_addr[j];
            if ({1'b0, w_off} < w_count_n)
                w_busy_n[w_qa] = 1'b1;
        end
        if (w_pop != 2'd0)
            w_busy_n[r_addr[r_head]] = 1'b1;
        if (w_pop == 2'd2)
            w_busy_n[r_addr[w_h1]] = 1'b1;
        w_busy_n[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_busy <= '0;
        else
            r_busy <= w_busy_n;
    end
`endif

`ifndef SYNTHESIS
    a_enq_when_full: assert property (@(posedge clock) disable iff (reset)
        !enq_ready |-> !(enq0_valid || enq1_valid))
        else $error("enqueue attempted while enq_ready is low");
`endif

endmodule

// File: doc/rf_writeback_scheduler.md
Name: rf_writeback_scheduler

Overview:
- Sequences all register-file writes for the dual-issue core. Both execution pipes enqueue completed results into a small in-order writeback queue.
- Each cycle the block drains up to two of the oldest entries onto the register file's two write ports (address/data/enable 0 and 1).
- Guarantees: no write to R0, and no two same-cycle writes to one register.
- Sits between the execute/commit stage and the register file write ports.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- DATA_W, 16, write data width.
- ADDR_W, 3, register address width (8 architectural registers).

Ports:
- clock  input  1  single system clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- enq0_valid  input  1  pipe-0 result valid; older than pipe 1 in the same cycle.
- enq0_addr  input  ADDR_W  pipe-0 destination register.
- enq0_data  input  DATA_W  pipe-0 result.
- enq1_valid  input  1  pipe-1 result valid.
- enq1_addr  input  ADDR_W  pipe-1 destination register.
- enq1_data  input  DATA_W  pipe-1 result.
- enq_ready  output  1  high when at least 2 entries are free.
- stall_wb  input  1  hold drain this cycle.
- wr0_enable  output  1  register-file write enable, port 0.
- wr0_address  output  ADDR_W  port-0 write address.
- wr0_data  output  DATA_W  port-0 write data.
- wr1_enable  output  1  register-file write enable, port 1.
- wr1_address  output  ADDR_W  port-1 write address.
- wr1_data  output  DATA_W  port-1 write data.
- count  output  log2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset, synchronous active-high:
  - head, tail and count cleared to 0.
  - All wr* outputs cleared to 0.
  - Any queued writes are discarded. Reset mid-operation flushes the queue; lost writes are not replayed.
- enq_ready:
  - Combinational from the registered count: (DEPTH - count) >= 2.
  - It does not account for a same-cycle drain.
- Enqueue, when enq_ready=1:
  - Each valid port with a nonzero address is written at tail, in order pipe 0 then pipe 1.
  - Tail advances by 0, 1 or 2, wrapping modulo DEPTH.
  - A valid result addressed to R0 is silently dropped and consumes no entry.
- Enqueue when enq_ready=0 is a protocol violation:
  - Inputs are ignored; no state changes.
  - This is flagged by a simulation-only assertion.
- Drain, when stall_wb=0:
  - The oldest min(count,2) entries, measured before this edge's enqueue, are popped.
  - They are loaded into the wr registers: oldest to port 0, next to port 1.
  - Head advances by the number popped.
- Drain, when stall_wb=1:
  - No pop; wr0_enable and wr1_enable are 0 next cycle.
  - Address and data registers hold their last value.
- Same-address collapse:
  - If two popped entries share an address, wr0_enable=0 and wr1 carries the younger value.
  - Exactly one write per register per cycle.
- Latency:
  - Entry enqueued at edge k can be popped at edge k+1 (wr outputs valid in the following cycle).
  - The register file commits it at edge k+2.
  - An enqueue into an empty queue never drains in the same edge.
- Simultaneous enqueue and drain: count_next = count + enq_count - pop_count.
- Pointer wrap is modulo DEPTH; full is count==DEPTH and empty is count==0, so there is no pointer-equality ambiguity.
- A single pop drives only port 0 (wr1_enable=0).
- No pop (empty queue or stall): both enables are 0.

Optional Feature:
- Macro: WB_BUSY_MASK_EN.
- Defined: adds output busy_mask, 2**ADDR_W bits, registered.
  - Bit i is set when any queued entry, or any wr port with its enable set, targets register i.
  - Bit 0 is always 0; reset value is all zeros.
  - Used by issue logic to stall readers of pending registers.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset, then enq0 R3=0x1234 only -> enq_ready=1, count=1; next edge wr0_enable=1, wr0_address=3, wr0_data=0x1234, wr1_enable=0; count=0.
- Same cycle enq0 R5=0xAAAA and enq1 R5=0xBBBB -> after drain wr0_enable=0, wr1_enable=1, wr1_address=5, wr1_data=0xBBBB.
- enq0 R0=0xFFFF and enq1 R2=0x0002 -> count=1; only R2 is written, via port 0.
- stall_wb=1 while enqueuing 2 pairs -> count=4, enq_ready=0; a third pair is ignored (count stays 4).
  - Release stall -> R-writes drain in order over 2 cycles, two per cycle.
- Continuous paired enqueue and drain for 10 cycles -> pointers wrap; write order matches enqueue order; count stays ≤2.
- count=3 with reset asserted mid-stream -> next cycle count=0, all wr enables 0, and no queued data is written afterward.
